// File: rtl/pattern_tx256.sv
// pattern_tx256 -- serial pattern transmitter that drives the 256-bit serial
// pattern detector.
//
// A WIDTH-bit pattern is loaded a byte at a time, then shifted out MSB first,
// one bit per clock, on either the signal line or the program line. The
// pattern is streamed repeat_cnt+1 times back to back. An index counter picks
// the bits, so the stored pattern is never altered.
//
// Ports:
//   clk         system clock, rising edge
//   clr         synchronous active-high reset
//   ld_en       write ld_data at the load pointer (honoured in IDLE only)
//   ld_data     pattern byte; byte k lands in [WIDTH-1-k*LOAD_W -: LOAD_W]
//   loaded      set once WIDTH/LOAD_W bytes have been written since clr
//   start       transmission request (single-cycle sample)
//   target      channel select, sampled with start: 0 = sig, 1 = prgm
//   repeat_cnt  extra frames after the first, sampled with start
//   stop        (PATTERN_TX_LOOP_EN only) end after the current frame
//   busy        transmission in progress (SHIFT or DONE)
//   sig_out     serial signal bit
//   prgm_out    serial program bit
//   prgm_en     shift enable for the detector's program register
//   frame_done  pulse on the last bit of each frame
//   done        pulse in the single cycle after the final frame
//
// Build option: define PATTERN_TX_LOOP_EN to add the stop input and make an
// all-ones repeat_cnt mean continuous transmission. Without it, all-ones
// simply means 2^CNT_W frames.

module pattern_tx256 #(
    parameter int WIDTH  = 256,
    parameter int LOAD_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              ld_en,
    input  logic [LOAD_W-1:0] ld_data,
    output logic              loaded,
    input  logic              start,
    input  logic              target,
    input  logic [CNT_W-1:0]  repeat_cnt,
`ifdef PATTERN_TX_LOOP_EN
    input  logic              stop,
`endif
    output logic              busy,
    output logic              sig_out,
    output logic              prgm_out,
    output logic              prgm_en,
    output logic              frame_done,
    output logic              done
);

    localparam int NB = WIDTH / LOAD_W;
    localparam int PW = (NB > 1) ? $clog2(NB) : 1;
    localparam int IW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             state, nstate;
    logic [IW-1:0]      idx, nidx;
    logic [CNT_W-1:0]   fcnt, nfcnt;
    logic               tgt, ntgt;
    logic [WIDTH-1:0]   pat, pat_d;
    logic [PW-1:0]      ptr;
    logic               wr, accept, more, hold_cnt;

`ifdef PATTERN_TX_LOOP_EN
    logic               loop_f;     // latched all-ones repeat: run until stop
    logic               stop_q;     // stop seen during the current transmission
`endif

    assign wr     = ld_en && (state == S_IDLE);
    assign accept = start && loaded && (state == S_IDLE);

`ifdef PATTERN_TX_LOOP_EN
    assign hold_cnt = loop_f;
    // stop in the last-bit cycle itself also ends the run
    assign more     = (loop_f || (fcnt != '0)) && !(stop_q || stop);
`else
    assign hold_cnt = 1'b0;
    assign more     = (fcnt != '0);
`endif

    // Pattern after this edge's write; the first bit sent on an accepting
    // edge sees a byte written on that same edge.
    always_comb begin
        pat_d = pat;
        if (wr)
            pat_d[WIDTH-1-int'(ptr)*LOAD_W -: LOAD_W] = ld_data;
    end

    always_comb begin
        nstate = state;
        nidx   = idx;
        nfcnt  = fcnt;
        ntgt   = tgt;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    nstate = S_SHIFT;
                    nidx   = IW'(WIDTH-1);
                    nfcnt  = repeat_cnt;
                    ntgt   = target;
                end
            end
            S_SHIFT: begin
                if (idx == '0) begin
                    if (more) begin
                        // next frame follows with no gap
                        nidx = IW'(WIDTH-1);
                        if (!hold_cnt)
                            nfcnt = fcnt - CNT_W'(1);
                    end else begin
                        nstate = S_DONE;
                    end
                end else begin
                    nidx = idx - IW'(1);
                end
            end
            S_DONE:  nstate = S_IDLE;
            default: nstate = S_IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so they line up with
    // the state they describe and come straight off flops.
    always_ff @(posedge clk) begin
        if (clr) begin
            state      <= S_IDLE;
            idx        <= '0;
            fcnt       <= '0;
            tgt        <= 1'b0;
            pat        <= '0;
            ptr        <= '0;
            loaded     <= 1'b0;
            busy       <= 1'b0;
            sig_out    <= 1'b0;
            prgm_out   <= 1'b0;
            prgm_en    <= 1'b0;
            frame_done <= 1'b0;
            done       <= 1'b0;
`ifdef PATTERN_TX_LOOP_EN
            loop_f     <= 1'b0;
            stop_q     <= 1'b0;
`endif
        end else begin
            state <= nstate;
            idx   <= nidx;
            fcnt  <= nfcnt;
            tgt   <= ntgt;
            pat   <= pat_d;
            if (wr) begin
                if (ptr == PW'(NB-1)) begin
                    ptr    <= '0;
                    loaded <= 1'b1;
                end else begin
                    ptr <= ptr + PW'(1);
                end
            end
`ifdef PATTERN_TX_LOOP_EN
            if (accept) begin
                loop_f <= &repeat_cnt;
                stop_q <= 1'b0;
            end else if (state == S_SHIFT && stop) begin
                stop_q <= 1'b1;
            end
`endif
            busy       <= (nstate != S_IDLE);
            sig_out    <= (nstate == S_SHIFT) && !ntgt && pat_d[nidx];
            prgm_out   <= (nstate == S_SHIFT) &&  ntgt && pat_d[nidx];
            prgm_en    <= (nstate == S_SHIFT) &&  ntgt;
            frame_done <= (nstate == S_SHIFT) && (nidx == '0);
            done       <= (nstate == S_DONE);
        end
    end

endmodule

// File: tb/tb_pattern_tx256.sv
module tb_pattern_tx256;

    localparam int W  = 256;
    localparam int NB = 32;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       ld_en = 1'b0;
    logic [7:0] ld_data = '0;
    logic       start = 1'b0;
    logic       target = 1'b0;
    logic [7:0] rep = '0;
    logic       stop = 1'b0;
    logic       loaded, busy, sig_out, prgm_out, prgm_en, frame_done, done;

    always #5 clk = ~clk;

    pattern_tx256 dut (
        .clk        (clk),
        .clr        (clr),
        .ld_en      (ld_en),
        .ld_data    (ld_data),
        .loaded     (loaded),
        .start      (start),
        .target     (target),
        .repeat_cnt (rep),
`ifdef PATTERN_TX_LOOP_EN
        .stop       (stop),
`endif
        .busy       (busy),
        .sig_out    (sig_out),
        .prgm_out   (prgm_out),
        .prgm_en    (prgm_en),
        .frame_done (frame_done),
        .done       (done)
    );

    // one expected output cycle of an active transmission (busy implied)
    typedef struct packed {
        logic sig;
        logic prgm;
        logic en;
        logic fd;
        logic dn;
    } exp_t;

    exp_t       q[$];
    exp_t       last_exp = '0;
    bit         last_busy = 1'b0;   // model: was the cycle just ended busy
    logic [W-1:0] m_pat = '0;
    int         m_ptr = 0;
    bit         m_loaded = 1'b0;
    bit         mon_on = 1'b0;
    int         total = 0;
    int         bad = 0;

    // monitor: every cycle compare all outputs against the queue head, or
    // against the idle values when nothing is expected
    initial forever begin
        @(negedge clk);
        if (mon_on) begin
            exp_t       e;
            logic [6:0] act_v, exp_v;
            act_v = {sig_out, prgm_out, prgm_en, frame_done, done, busy, loaded};
            if (q.size() > 0) begin
                e         = q.pop_front();
                exp_v     = {e, 1'b1, m_loaded};
                last_busy = 1'b1;
                last_exp  = e;
            end else begin
                exp_v     = {5'b0, 1'b0, m_loaded};
                last_busy = 1'b0;
                last_exp  = '0;
            end
            total++;
            if (act_v !== exp_v) begin
                bad++;
                $display("FAIL outputs t=%0t {sig,prgm,en,fd,done,busy,loaded} got=%b want=%b",
                         $time, act_v, exp_v);
            end
        end
    end

    // expected stream: (rp+1) frames of the pattern MSB first, then DONE
    task automatic push_tx(input bit tg, input logic [7:0] rp);
        int   frames;
        exp_t e;
        frames = int'(rp) + 1;
`ifdef PATTERN_TX_LOOP_EN
        if (rp == 8'hFF) frames = 8;    // continuous; only used with stop
`endif
        for (int f = 0; f < frames; f++)
            for (int b = W - 1; b >= 0; b--) begin
                e.sig  = !tg && m_pat[b];
                e.prgm = tg && m_pat[b];
                e.en   = tg;
                e.fd   = (b == 0);
                e.dn   = 1'b0;
                q.push_back(e);
            end
        q.push_back(exp_t'(5'b00001));
    endtask

    // stop: keep the rest of the current frame, then DONE
    task automatic truncate();
        int k;
        if (last_exp.fd) begin
            q.delete();
        end else begin
            k = 0;
            while (k < q.size() && !q[k].fd) k++;
            while (q.size() > k + 1) void'(q.pop_back());
        end
        q.push_back(exp_t'(5'b00001));
    endtask

    // one clock: drive at negedge, update model after the edge, return at negedge
    task automatic step(input bit c, input bit le, input logic [7:0] ld,
                        input bit st, input bit tg, input logic [7:0] rp, input bit sp);
        clr = c; ld_en = le; ld_data = ld; start = st; target = tg; rep = rp; stop = sp;
        @(posedge clk);
        if (c) begin
            q.delete();
            m_pat = '0; m_ptr = 0; m_loaded = 1'b0;
        end else begin
            if (le && !last_busy) begin
                m_pat[W-1-m_ptr*8 -: 8] = ld;
                if (m_ptr == NB - 1) m_loaded = 1'b1;
                m_ptr = (m_ptr + 1) % NB;
            end
`ifdef PATTERN_TX_LOOP_EN
            if (sp && last_busy && !last_exp.dn) truncate();
`endif
            if (st && m_loaded && !last_busy) push_tx(tg, rp);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0, 0, 8'h00, 0);
    endtask

    task automatic load(input logic [7:0] b);
        step(0, 1, b, 0, 0, 8'h00, 0);
    endtask

    task automatic go(input bit tg, input logic [7:0] rp);
        step(0, 0, 8'h00, 1, tg, rp, 0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q.size() > 0 || last_busy) && n < 70000) begin
            idle(1);
            n++;
        end
        total++;
        if (n >= 70000) begin
            bad++;
            $display("FAIL wait_idle timeout got=%0d cycles want<70000", n);
        end
        idle(1);
    endtask

    initial begin
        // reset
        step(1, 0, 8'h00, 0, 0, 8'h00, 0);
        step(1, 0, 8'h00, 0, 0, 8'h00, 0);
        @(negedge clk);
        mon_on = 1'b1;
        idle(3);

        // A5, 00.., 3C on sig, single frame
        for (int k = 0; k < NB; k++)
            load(k == 0 ? 8'hA5 : (k == NB - 1 ? 8'h3C : 8'h00));
        go(0, 8'd0);
        wait_idle();

        // all ones on prgm, three frames (overwrites in place, loaded held)
        for (int k = 0; k < NB; k++) load(8'hFF);
        go(1, 8'd2);
        wait_idle();

        // start with only 31 bytes is ignored; 32nd write enables it
        step(1, 0, 8'h00, 0, 0, 8'h00, 0);
        for (int k = 0; k < NB - 1; k++) load(8'($urandom));
        go(0, 8'd0);
        idle(2);
        load(8'($urandom));
        go(0, 8'd0);
        wait_idle();

        // writes and starts during SHIFT/DONE are ignored
        for (int k = 0; k < NB; k++) load(8'hFF);
        go(0, 8'd1);
        for (int i = 0; i < 300; i++) step(0, 1, 8'h00, 1, 1, 8'd3, 0);
        wait_idle();
        go(0, 8'd0);
        wait_idle();

        // clr at cycle 100 aborts; later start ignored until reloaded
        go(1, 8'd0);
        idle(99);
        step(1, 0, 8'h00, 0, 0, 8'h00, 0);
        idle(2);
        go(0, 8'd0);
        idle(3);

        // randomized: partial rewrites (pointer wraps), channel, repeats, noise
        for (int k = 0; k < NB; k++) load(8'($urandom));
        for (int it = 0; it < 6; it++) begin
            int nw;
            nw = $urandom_range(0, 40);
            for (int k = 0; k < nw; k++) load(8'($urandom));
            go(1'($urandom), 8'($urandom_range(0, 1)));
            for (int i = 0; i < 100; i++)
                step(0, 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 0);
            wait_idle();
        end

`ifdef PATTERN_TX_LOOP_EN
        // continuous until stop at cycle 1000: ends at 1024, done at 1025
        for (int k = 0; k < NB; k++) load(8'($urandom));
        go(0, 8'hFF);
        idle(999);
        step(0, 0, 8'h00, 0, 0, 8'h00, 1);
        wait_idle();
        // stop cuts a finite repeat short; stop in IDLE does nothing
        step(0, 0, 8'h00, 0, 0, 8'h00, 1);
        go(1, 8'd3);
        idle(9);
        step(0, 0, 8'h00, 0, 0, 8'h00, 1);
        wait_idle();
`endif

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pattern_tx256.md
Name: pattern_tx256

Overview:
- Serial pattern transmitter: the driving end of the 256-bit serial pattern detector.
- Holds a 256-bit pattern loaded through a byte-wide write port.
- Shifts the pattern out one bit per clock on either the signal line (sig_out) or the program line (prgm_out, with prgm_en).
- Used in the bench and on-chip to program the detector and to stream match/mismatch frames into it.

Parameters:
- WIDTH, 256, pattern length in bits; must be a multiple of LOAD_W.
- LOAD_W, 8, load-port byte width.
- CNT_W, 8, width of the repeat-count input.

Ports:
- clk  input  1  system clock, rising edge
- clr  input  1  synchronous active-high reset
- ld_en  input  1  write ld_data into the pattern at the current load pointer
- ld_data  input  LOAD_W  pattern byte
- loaded  output  1  high once WIDTH/LOAD_W bytes have been written since reset
- start  input  1  request transmission (single-cycle sample)
- target  input  1  0 = sig channel, 1 = prgm channel; sampled with start
- repeat  input  CNT_W  additional frames after the first; sampled with start
- busy  output  1  transmission in progress
- sig_out  output  1  serial signal bit
- prgm_out  output  1  serial program bit
- prgm_en  output  1  shift enable for the detector's program register
- frame_done  output  1  one-cycle pulse on the last bit of each frame
- done  output  1  one-cycle pulse after the final frame

Behaviour:
- Reset (clr=1 at a clock edge), takes priority over everything:
  - Pattern register cleared to 0; load pointer = 0; loaded = 0.
  - State = IDLE; all outputs = 0.
  - A reset mid-frame aborts the frame immediately; no done pulse.
- Load:
  - Accepted only in IDLE; ld_en in SHIFT or DONE is ignored.
  - Byte k occupies bits [WIDTH-1-k*LOAD_W -: LOAD_W], so the first byte lands in [255:248].
  - The pointer increments per write and wraps from 31 to 0.
  - loaded sets on the 32nd write and stays set until clr; later writes overwrite in place.
- State machine states: IDLE, SHIFT, DONE.
  - IDLE -> SHIFT when start=1 and loaded=1. Otherwise start is ignored. start in SHIFT or DONE is ignored.
  - On acceptance at edge N, target and repeat are latched; bit index = WIDTH-1; frame counter = repeat.
  - SHIFT: all outputs are registered.
    - Bit 255 is valid in the cycle after edge N; bit 0 is valid 256 cycles after edge N.
    - Transmission order is MSB first, so a shift-left SIPO holds the pattern unaltered after 256 enabled edges.
    - Selected channel carries pattern[index]; the unselected serial output is held 0.
    - prgm_en = 1 in every cycle a prgm bit is valid, otherwise 0.
    - busy = 1.
  - Last bit of a frame (index 0): frame_done = 1 in the same cycle.
    - If frame counter > 0: decrement it, reload index = WIDTH-1, and start the next frame in the following cycle with no gap.
    - If frame counter = 0: go to DONE.
  - DONE lasts one cycle: done = 1, busy = 1, serial outputs = 0, prgm_en = 0. Then go to IDLE.
- Total frames = repeat+1. repeat = 255 gives 256 frames (65536 bits).
- Transmission is non-destructive: an index counter selects bits, so the pattern register is unchanged after transmission.
- In IDLE: busy = 0, frame_done = 0, done = 0.

Optional Feature:
- Macro: PATTERN_TX_LOOP_EN.
- When defined:
  - Adds input stop (1 bit).
  - A latched repeat of all ones means continuous transmission; the frame counter is not decremented.
  - stop=1 in any SHIFT cycle is remembered; the current frame completes, then DONE.
  - stop also terminates finite repeats after the current frame.
  - In IDLE, stop has no effect.
- When undefined:
  - No stop port.
  - All-ones repeat means exactly 2^CNT_W frames.

Test Plan:
- Reset, write 32 bytes 0xA5, 0x00, …, 0x00, 0x3C (0xA5 first, 0x3C last), start with target=0, repeat=0:
  - Cycles 1..8 after acceptance show sig_out = 1,0,1,0,0,1,0,1.
  - Cycles 249..256 show 0,0,1,1,1,1,0,0.
  - frame_done pulses at cycle 256; done pulses at cycle 257; prgm_out = prgm_en = 0 throughout.
- Pattern 0xFF…FF, target=1, repeat=2:
  - prgm_en and prgm_out high for 768 contiguous cycles.
  - frame_done pulses at cycles 256, 512 and 768; done pulses at 769; sig_out = 0 throughout.
- start with only 31 bytes written:
  - Ignored: busy stays 0.
  - The 32nd write raises loaded; a following start is accepted.
- ld_en=1 with 0x00 during SHIFT of pattern 0xFF…FF, repeat=1:
  - Write ignored; both frames transmit all ones.
  - After done, a new start again transmits all ones.
- clr asserted at cycle 100 of a frame:
  - All outputs 0 the next cycle; loaded = 0; no done pulse.
  - start before any reload is ignored.
- With PATTERN_TX_LOOP_EN, repeat=8'hFF, stop pulsed at cycle 1000:
  - Transmission ends at cycle 1024 with frame_done.
  - done pulses at cycle 1025.
